nes_cpu_mem_bus: RTL and testbench

Parametrised CPU-side memory subsystem for the NES 6502 core. It decodes the 16-bit CPU bus into RAM, I/O-register, SRAM and ROM regions, applying NES mirroring. Each region has a configurable wait-state count, stretched through the `rdy` handshake. It also provides a ROM preload port, write protection, open-bus reads and I/O access strobes. It replaces the fixed-size behavioural memories used in the CPU bench and sits between the CPU and the on-chip memories.

---
 rtl/nes_cpu_mem_bus.sv | 176 +++++++++++++++++
 tb/tb_nes_cpu_mem_bus.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_cpu_mem_bus.sv
// nes_cpu_mem_bus: CPU-side memory map for the NES 6502 core.
// RAM/IO/SRAM/ROM decode with mirroring and per-region wait states.
module nes_cpu_mem_bus #(
  parameter int RAM_AW    = 11,
  parameter int IO_AW     = 3,
  parameter int SRAM_AW   = 13,
  parameter int ROM_AW    = 15,
  parameter int RAM_WAIT  = 0,
  parameter int IO_WAIT   = 0,
  parameter int SRAM_WAIT = 0,
  parameter int ROM_WAIT  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [15:0]               cpu_addr_out,
  input  logic [7:0]                cpu_data_out,
  input  logic                      ren,
  input  logic                      wen,
  output logic [7:0]                cpu_data_in,
  output logic                      rdy,
  output logic [8*(1<<IO_AW)-1:0]   io_regs_o,
  output logic [(1<<IO_AW)-1:0]     io_wr_stb,
  output logic [(1<<IO_AW)-1:0]     io_rd_stb,
  input  logic                      rom_ld_we,
  input  logic [ROM_AW-1:0]         rom_ld_addr,
  input  logic [7:0]                rom_ld_data,
  output logic                      err
);
  localparam int NIO = 1 << IO_AW;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d, lat;
  logic [15:0] a_q, c_addr;
  logic [7:0]  d_q, c_data;
  logic        wr_q, c_wr;
  logic        accept, go;
  logic        hit_ram, hit_io, hit_sram, hit_rom;

  logic [RAM_AW-1:0]  ram_i;
  logic [IO_AW-1:0]   io_i;
  logic [SRAM_AW-1:0] sram_i;
  logic [ROM_AW-1:0]  rom_i;

  logic [7:0] ram  [1<<RAM_AW];
  logic [7:0] sram [1<<SRAM_AW];
  logic [7:0] rom  [1<<ROM_AW];
  logic [7:0] io_r [NIO];

  function automatic logic [3:0] wait_of(
    input logic [2:0] hi
  );
    logic [3:0] w;
    w = '0;
    unique case (1'b1)
      hi[2]:         w = 4'(ROM_WAIT);
      hi == 3'b000:  w = 4'(RAM_WAIT);
      hi == 3'b001:  w = 4'(IO_WAIT);
      hi == 3'b011:  w = 4'(SRAM_WAIT);
      default:       w = '0;
    endcase
    return w;
  endfunction

  assign lat = wait_of(cpu_addr_out[15:13]);
  assign rdy = state == S_IDLE;

  // IDLE completes from the live bus; WAIT replays the latched request
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    accept  = 1'b0;
    go      = 1'b0;
    c_addr  = cpu_addr_out;
    c_data  = cpu_data_out;
    c_wr    = wen;
    unique case (state)
      S_IDLE: begin
        if (ren || wen) begin
          accept = 1'b1;
          if (lat == 4'd0) begin
            go = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = lat;
          end
        end
      end
      S_WAIT: begin
        c_addr = a_q;
        c_data = d_q;
        c_wr   = wr_q;
        cnt_d  = cnt - 4'd1;
        if (cnt == 4'd1) begin
          go      = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  assign hit_ram  = c_addr[15:13] == 3'b000;
  assign hit_io   = c_addr[15:13] == 3'b001;
  assign hit_sram = c_addr[15:13] == 3'b011;
  assign hit_rom  = c_addr[15];

  assign ram_i  = c_addr[RAM_AW-1:0];
  assign io_i   = c_addr[IO_AW-1:0];
  assign sram_i = c_addr[SRAM_AW-1:0];
  assign rom_i  = c_addr[ROM_AW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      err         <= 1'b0;
      cpu_data_in <= '0;
      io_wr_stb   <= '0;
      io_rd_stb   <= '0;
      for (int i = 0; i < NIO; i++)
        io_r[i] <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      io_wr_stb <= '0;
      io_rd_stb <= '0;
      if (accept && wen && (ren || cpu_addr_out[15]))
        err <= 1'b1;
      if (go && !c_wr) begin
        unique case (1'b1)
          hit_ram:  cpu_data_in <= ram[ram_i];
          hit_io: begin
            cpu_data_in     <= io_r[io_i];
            io_rd_stb[io_i] <= 1'b1;
          end
          hit_sram: cpu_data_in <= sram[sram_i];
          hit_rom:  cpu_data_in <= rom[rom_i];
          default: ;
        endcase
      end
      if (go && c_wr && hit_io) begin
        io_r[io_i]      <= c_data;
        io_wr_stb[io_i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= cpu_addr_out;
      d_q  <= cpu_data_out;
      wr_q <= wen;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && go && c_wr) begin
      if (hit_ram)
        ram[ram_i] <= c_data;
      if (hit_sram)
        sram[sram_i] <= c_data;
    end
  end

  // Old byte wins on a same-edge preload/read collision
  always_ff @(posedge clk) begin
    if (!rst && rom_ld_we)
      rom[rom_ld_addr] <= rom_ld_data;
  end

  for (genvar g = 0; g < NIO; g++) begin : g_io
    assign io_regs_o[8*g +: 8] = io_r[g];
  end

endmodule

// File: tb/tb_nes_cpu_mem_bus.sv
// tb_nes_cpu_mem_bus: randomized scoreboard bench for nes_cpu_mem_bus.
// Driver pushes model expectations; a monitor pops them on completion.
module tb_nes_cpu_mem_bus;
  localparam int RAM_AW = 11;
  localparam int IO_AW  = 3;
  localparam int SRAM_AW = 13;
  localparam int ROM_AW = 15;
  localparam int RAM_W  = 0;
  localparam int IO_W   = 0;
  localparam int SRAM_W = 4;
  localparam int ROM_W  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr_out = '0;
  logic [7:0]  cpu_data_out = '0;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic [7:0]  cpu_data_in;
  logic        rdy;
  logic [63:0] io_regs_o;
  logic [7:0]  io_wr_stb;
  logic [7:0]  io_rd_stb;
  logic        rom_ld_we = 1'b0;
  logic [14:0] rom_ld_addr = '0;
  logic [7:0]  rom_ld_data = '0;
  logic        err;

  nes_cpu_mem_bus #(
    .RAM_AW(RAM_AW), .IO_AW(IO_AW),
    .SRAM_AW(SRAM_AW), .ROM_AW(ROM_AW),
    .RAM_WAIT(RAM_W), .IO_WAIT(IO_W),
    .SRAM_WAIT(SRAM_W), .ROM_WAIT(ROM_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_addr_out(cpu_addr_out),
    .cpu_data_out(cpu_data_out),
    .ren(ren), .wen(wen),
    .cpu_data_in(cpu_data_in), .rdy(rdy),
    .io_regs_o(io_regs_o),
    .io_wr_stb(io_wr_stb), .io_rd_stb(io_rd_stb),
    .rom_ld_we(rom_ld_we), .rom_ld_addr(rom_ld_addr),
    .rom_ld_data(rom_ld_data), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic [7:0]  wstb;
    logic [7:0]  rstb;
    logic        err;
    logic [63:0] io;
    int          lat;
    bit          abort;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;

  logic [7:0]  ram_m  [2048];
  logic [7:0]  sram_m [8192];
  logic [7:0]  rom_m  [32768];
  logic [63:0] io_m = '0;
  logic [7:0]  last_rd = '0;
  logic        err_m = 1'b0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic model_reset();
    err_m   = 1'b0;
    io_m    = '0;
    last_rd = '0;
  endtask

  task automatic issue(input logic [15:0] a,
                       input logic [7:0] d,
                       input bit r, input bit w,
                       input bit abort = 1'b0,
                       input string nm = "acc");
    exp_t e;
    int g, rg, L;
    g = 0;
    while (!rdy && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!rdy) chk("issue_rdy_timeout", 64'(rdy), 1);
    if (a < 16'h2000)      begin rg = 0; L = RAM_W;  end
    else if (a < 16'h4000) begin rg = 1; L = IO_W;   end
    else if (a < 16'h6000) begin rg = 2; L = 0;      end
    else if (a < 16'h8000) begin rg = 3; L = SRAM_W; end
    else                   begin rg = 4; L = ROM_W;  end
    if (r && w) err_m = 1'b1;
    if (w && rg == 4) err_m = 1'b1;
    e.data = last_rd;
    e.wstb = '0;
    e.rstb = '0;
    if (!w) begin
      case (rg)
        0: e.data = ram_m[a % 2048];
        1: begin
          e.data = io_m[8*(a % 8) +: 8];
          e.rstb = 8'(1 << (a % 8));
        end
        3: e.data = sram_m[a % 8192];
        4: e.data = rom_m[a % 32768];
        default: ;
      endcase
      last_rd = e.data;
    end else if (!abort) begin
      case (rg)
        0: ram_m[a % 2048] = d;
        1: begin
          io_m[8*(a % 8) +: 8] = d;
          e.wstb = 8'(1 << (a % 8));
        end
        3: sram_m[a % 8192] = d;
        default: ;
      endcase
    end
    e.err   = err_m;
    e.io    = io_m;
    e.lat   = L;
    e.abort = abort;
    e.name  = nm;
    exp_q.push_back(e);
    cpu_addr_out = a;
    cpu_data_out = d;
    ren = r;
    wen = w;
    @(posedge clk);
    @(negedge clk);
    ren = 1'b0;
    wen = 1'b0;
  endtask

  task automatic preload(input logic [14:0] a,
                         input logic [7:0] d);
    rom_ld_we   = 1'b1;
    rom_ld_addr = a;
    rom_ld_data = d;
    @(posedge clk);
    @(negedge clk);
    rom_ld_we = 1'b0;
    rom_m[a] = d;
  endtask

  initial begin : monitor
    int   lat;
    bit   ab;
    exp_t e;
    forever begin
      @(posedge clk);
      if (!rst && rdy && (ren || wen)) begin
        lat = 0;
        ab  = 1'b0;
        #1;
        while (!rdy && lat < 40) begin
          @(posedge clk);
          if (rst) ab = 1'b1;
          #1;
          lat++;
        end
        if (exp_q.size() == 0) begin
          chk("unexpected_access", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk({e.name, "_abort"}, 64'(ab), 64'(e.abort));
          if (e.abort) begin
            chk("rst_rdy", 64'(rdy), 1);
            chk("rst_data", 64'(cpu_data_in), 0);
            chk("rst_io", io_regs_o, 0);
            chk("rst_stb", {io_wr_stb, io_rd_stb}, 0);
            chk("rst_err", 64'(err), 0);
          end else begin
            chk({e.name, "_lat"}, 64'(lat), 64'(e.lat));
            chk({e.name, "_data"}, 64'(cpu_data_in),
                64'(e.data));
            chk({e.name, "_wstb"}, 64'(io_wr_stb),
                64'(e.wstb));
            chk({e.name, "_rstb"}, 64'(io_rd_stb),
                64'(e.rstb));
            chk({e.name, "_err"}, 64'(err), 64'(e.err));
            chk({e.name, "_io"}, io_regs_o, e.io);
          end
        end
      end
    end
  end

  initial begin : driver
    logic [15:0] a;
    logic [7:0]  nv;
    int op, rg, g;
    repeat (3) @(negedge clk);
    chk("reset_rdy", 64'(rdy), 1);
    chk("reset_data", 64'(cpu_data_in), 0);
    chk("reset_io", io_regs_o, 0);
    chk("reset_stb", {io_wr_stb, io_rd_stb}, 0);
    chk("reset_err", 64'(err), 0);
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < 16; i++) begin
      preload(15'(i), 8'($urandom));
      preload(15'(16'h7FF0 + i), 8'($urandom));
      issue(16'(i), 8'($urandom), 0, 1, 0, "init_ram");
      issue(16'(16'h6010 + i), (i == 0) ? 8'h00 : 8'($urandom),
            0, 1, 0, "init_sram");
    end
    preload(15'h0000, 8'h4C);
    preload(15'h7FFC, 8'h3C);

    issue(16'h0005, 8'hA5, 0, 1, 0, "mirror_wr");
    issue(16'h1805, 8'h00, 1, 0, 0, "mirror_rd");

    issue(16'hFFFC, 8'h00, 1, 0, 0, "rom_rd");
    issue(16'hFFFC, 8'h00, 0, 1, 0, "rom_wr");
    issue(16'hFFFC, 8'h00, 1, 0, 0, "rom_reread");

    issue(16'hFFF1, 8'h00, 1, 0, 0, "collide_rd");
    repeat (2) @(negedge clk);
    preload(15'h7FF1, rom_m[15'h7FF1] ^ 8'hFF);
    issue(16'hFFF1, 8'h00, 1, 0, 0, "collide_new");

    issue(16'h2000, 8'h80, 0, 1, 0, "io_wr0");
    issue(16'h3FF9, 8'h1F, 0, 1, 0, "io_wr1");
    issue(16'h2001, 8'h00, 1, 0, 0, "io_rd1");

    issue(16'h8000, 8'h00, 1, 0, 0, "ob_rom");
    issue(16'h4000, 8'h00, 1, 0, 0, "ob_rd");
    issue(16'h5000, 8'hEE, 0, 1, 0, "ob_wr");
    issue(16'h4000, 8'h00, 1, 0, 0, "ob_rd2");

    issue(16'h6010, 8'h77, 0, 1, 1, "rst_wait");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    issue(16'h6010, 8'h00, 1, 0, 0, "sram_after_rst");

    issue(16'h0100, 8'h11, 1, 1, 0, "conflict");
    issue(16'h0100, 8'h00, 1, 0, 0, "conflict_rd");

    for (int n = 0; n < 400; n++) begin
      rg = $urandom_range(0, 4);
      case (rg)
        0: a = 16'($urandom_range(0, 3) * 2048
                   + $urandom_range(0, 15));
        1: a = 16'(16'h2000 + $urandom_range(0, 1023) * 8
                   + $urandom_range(0, 7));
        2: a = 16'(16'h4000 + $urandom_range(0, 16'h1FFF));
        3: a = 16'(16'h6010 + $urandom_range(0, 15));
        default: a = 16'(16'h8000
                   + ($urandom_range(0, 1) ? 16'h7FF0 : 16'h0)
                   + $urandom_range(0, 15));
      endcase
      op = $urandom_range(0, 19);
      nv = 8'($urandom);
      issue(a, nv, op < 12 || op == 19, op >= 12, 0, "rnd");
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("drain", 64'(exp_q.size()), 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("final_err_clear", 64'(err), 0);
    chk("final_rdy", 64'(rdy), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
